// File: rtl/adc_spi_pkg.sv
// Shared types and ADC register constants for the ADC SPI sequencer.
// The default init table powers the ADC up, then sets timing, mode and output format.
package adc_spi_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_SEL,
        ST_START,
        ST_ARM,
        ST_RUN,
        ST_DONE,
        ST_IDLE
    } state_t;

    typedef struct packed {
        logic        rw;
        logic [15:0] adr;
        logic [15:0] dat;
    } cmd_t;

    localparam logic [15:0] ADR_PDWN = 16'h0001;
    localparam logic [15:0] ADR_TIM  = 16'h0002;
    localparam logic [15:0] ADR_MODE = 16'h0003;
    localparam logic [15:0] ADR_FORM = 16'h0004;

    localparam logic [15:0] DAT_PDWN = 16'h0000;
    localparam logic [15:0] DAT_TIM  = 16'h0001;
    localparam logic [15:0] DAT_MODE = 16'h0002;
    localparam logic [15:0] DAT_FORM = 16'h0000;

    // Entry 0 sits in the low 32 bits and is sent first.
    localparam logic [127:0] INIT_TAB_DEFAULT = {
        ADR_FORM, DAT_FORM,
        ADR_MODE, DAT_MODE,
        ADR_TIM,  DAT_TIM,
        ADR_PDWN, DAT_PDWN
    };

    localparam logic [15:0] TMO_RDATA = 16'hDEAD;

endpackage

// File: rtl/adc_spi_ctrl.sv
// Sequencer/arbiter in front of the ADC SPI master: power-up wait, init table playback,
// then host access via req/ack, with a start-to-busy timeout that flags a stuck master.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_PWR_WAIT | counting the power-up interval after reset
// ST_SEL      | choosing next command (pending init > unfinished table > host)
// ST_START    | spi_start_o high for one cycle, timeout counter armed
// ST_ARM      | waiting for spi_busy_i to rise, timeout counting down
// ST_RUN      | waiting for spi_busy_i to fall
// ST_DONE     | one-cycle completion (ack / init_done visible)
// ST_IDLE     | nothing pending
module adc_spi_ctrl
    import adc_spi_pkg::*;
#(
    parameter int unsigned               INIT_WAIT = 12500000,
    parameter int unsigned               INIT_NUM  = 4,
    parameter logic [INIT_NUM*32-1:0]    INIT_TAB  = INIT_TAB_DEFAULT,
    parameter int unsigned               TMO       = 64
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        init_start_i,
    input  logic        host_req_i,
    input  logic        host_rw_i,
    input  logic [15:0] host_adr_i,
    input  logic [15:0] host_dat_i,
    output logic        host_ack_o,
    output logic [15:0] host_rdata_o,
    output logic        init_done_o,
    output logic        err_o,
    output logic        spi_start_o,
    output logic        spi_rw_o,
    output logic [15:0] spi_adr_o,
    output logic [15:0] spi_dat_o,
    input  logic        spi_busy_i,
    input  logic [15:0] spi_rdata_i
);

    localparam int WAIT_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT + 1) : 1;
    localparam int TMO_W  = ($clog2(TMO + 1) > 7) ? $clog2(TMO + 1) : 7;
    localparam int IDX_W  = (INIT_NUM > 1) ? $clog2(INIT_NUM) : 1;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(INIT_WAIT - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(INIT_NUM - 1);

    state_t            state;
    cmd_t              cmd;
    logic              cmd_host;
    logic [WAIT_W-1:0] wait_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [IDX_W-1:0]  init_idx;
    logic              init_pend;

    logic [31:0]       tab_ent;
    logic              tmo_hit;
    logic              xfer_end;

    assign tab_ent  = INIT_TAB[{init_idx, 5'b0} +: 32];
    assign tmo_hit  = (state == ST_ARM) && !spi_busy_i && (tmo_cnt == '0);
    assign xfer_end = tmo_hit || ((state == ST_RUN) && !spi_busy_i);

    assign spi_rw_o  = cmd.rw;
    assign spi_adr_o = cmd.adr;
    assign spi_dat_o = cmd.dat;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state        <= ST_PWR_WAIT;
            cmd          <= '0;
            cmd_host     <= 1'b0;
            wait_cnt     <= '0;
            tmo_cnt      <= '0;
            init_idx     <= '0;
            init_pend    <= 1'b0;
            spi_start_o  <= 1'b0;
            host_ack_o   <= 1'b0;
            host_rdata_o <= '0;
            init_done_o  <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            spi_start_o <= 1'b0;
            host_ack_o  <= 1'b0;
            if (init_start_i) begin
                init_pend <= 1'b1;
            end

            case (state)
                ST_PWR_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ST_SEL;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_SEL: begin
                    // Never start while the master still reports busy (e.g. after a timeout).
                    if (spi_busy_i) begin
                        state <= ST_SEL;
                    end else if (init_pend) begin
                        init_pend   <= 1'b0;
                        init_done_o <= 1'b0;
                        err_o       <= 1'b0;
                        init_idx    <= '0;
                        cmd         <= {1'b0, INIT_TAB[31:0]};
                        cmd_host    <= 1'b0;
                        spi_start_o <= 1'b1;
                        state       <= ST_START;
                    end else if (!init_done_o) begin
                        cmd         <= {1'b0, tab_ent};
                        cmd_host    <= 1'b0;
                        spi_start_o <= 1'b1;
                        state       <= ST_START;
                    end else if (host_req_i) begin
                        cmd         <= {host_rw_i, host_adr_i, host_dat_i};
                        cmd_host    <= 1'b1;
                        spi_start_o <= 1'b1;
                        state       <= ST_START;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_START: begin
                    tmo_cnt <= TMO_LAST;
                    state   <= ST_ARM;
                end
                ST_ARM: begin
                    if (spi_busy_i) begin
                        state <= ST_RUN;
                    end else if (tmo_cnt != '0) begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                ST_DONE: begin
                    state <= ST_SEL;
                end
                ST_IDLE: begin
                    if (init_start_i || host_req_i) begin
                        state <= ST_SEL;
                    end
                end
                default: begin
                    state <= ST_PWR_WAIT;
                end
            endcase

            // Completion bookkeeping lands on entry to DONE so it is visible during DONE.
            if (xfer_end) begin
                state <= ST_DONE;
                if (tmo_hit) begin
                    err_o <= 1'b1;
                end
                if (cmd_host) begin
                    host_ack_o <= 1'b1;
                    if (tmo_hit) begin
                        host_rdata_o <= TMO_RDATA;
                    end else if (cmd.rw) begin
                        host_rdata_o <= spi_rdata_i;
                    end
                end else if (init_idx == IDX_LAST) begin
                    init_done_o <= 1'b1;
                    init_idx    <= '0;
                end else begin
                    init_idx <= init_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule
